// File: rtl/instruction_queue.sv
// Instruction queue: DEPTH-entry FIFO of fetched words with valid/ready
// handshakes, decoding the head entry into fields plus an extended immediate.
// Ports: clk, reset (async, active-low), flush (sync discard),
//   in_valid/in_ready/instruction_in (fetch side),
//   out_valid/out_ready (decode side), opcode, reg_dest, reg_source_1,
//   reg_source_2, immediate, immediate_ext (head fields), count (occupancy).
module instruction_queue #(
  parameter  int OPCODE_W     = 4,
  parameter  int REG_ADDR_W   = 4,
  parameter  int IMM_W        = 16,
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 4,
  parameter  bit IMM_SIGN_EXT = 1'b1,
  localparam int INSTR_W      = OPCODE_W + 3*REG_ADDR_W + IMM_W,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instruction_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] reg_dest,
  output logic [REG_ADDR_W-1:0] reg_source_1,
  output logic [REG_ADDR_W-1:0] reg_source_2,
  output logic [IMM_W-1:0]      immediate,
  output logic [DATA_WIDTH-1:0] immediate_ext,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EXT_W = DATA_WIDTH - IMM_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [INSTR_W-1:0] head;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= instruction_in;
  end

  // Empty queue presents zeros rather than whatever stale word sits at rptr.
  assign head = out_valid ? mem_q[rptr_q] : '0;

  assign {opcode, reg_dest, reg_source_1, reg_source_2, immediate} = head;

  generate
    if (EXT_W == 0) begin : g_no_ext
      assign immediate_ext = immediate;
    end else if (IMM_SIGN_EXT) begin : g_sext
      assign immediate_ext = {{EXT_W{immediate[IMM_W-1]}}, immediate};
    end else begin : g_zext
      assign immediate_ext = {{EXT_W{1'b0}}, immediate};
    end
  endgenerate

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: reset, decode, full/empty,
// streaming across wrap, backpressure, flush priority and async reset.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready_z;
  logic [31:0] instruction_in;
  logic        out_valid, out_valid_z;
  logic        out_ready;
  logic [3:0]  opcode, reg_dest, reg_source_1, reg_source_2;
  logic [3:0]  opcode_z, reg_dest_z, reg_source_1_z, reg_source_2_z;
  logic [15:0] immediate, immediate_z;
  logic [31:0] immediate_ext, immediate_ext_z;
  logic [2:0]  count, count_z;

  int checks = 0;
  int failures = 0;

  always begin
    #5 clk = clk_en ? ~clk : 1'b0;
  end

  instruction_queue u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .reg_dest(reg_dest),
    .reg_source_1(reg_source_1), .reg_source_2(reg_source_2),
    .immediate(immediate), .immediate_ext(immediate_ext),
    .count(count)
  );

  instruction_queue #(.IMM_SIGN_EXT(1'b0)) u_dut_z (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_z),
    .instruction_in(instruction_in),
    .out_valid(out_valid_z), .out_ready(out_ready),
    .opcode(opcode_z), .reg_dest(reg_dest_z),
    .reg_source_1(reg_source_1_z), .reg_source_2(reg_source_2_z),
    .immediate(immediate_z), .immediate_ext(immediate_ext_z),
    .count(count_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    instruction_in = '0;

    // reset asserted mid-cycle, before any clock edge
    #3 reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", opcode, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // single word decode
    instruction_in = 32'h1A5F_8001;
    in_valid = 1'b1;
    #1 chk("no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_opcode", opcode, 4'h1);
    chk("t1_rd", reg_dest, 4'hA);
    chk("t1_rs1", reg_source_1, 4'h5);
    chk("t1_rs2", reg_source_2, 4'hF);
    chk("t1_imm", immediate, 16'h8001);
    chk("t1_sext", immediate_ext, 32'hFFFF_8001);
    chk("t1_zext", immediate_ext_z, 32'h0000_8001);
    chk("t1_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_pop_count", count, 0);
    chk("t1_pop_ext", immediate_ext, 0);

    // fill to full, fifth word refused
    for (int i = 1; i <= 5; i++) begin
      instruction_in = 32'(i);
      in_valid = 1'b1;
      if (i == 5) chk("full_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_imm", immediate, 64'(i));
      chk("drain_op", opcode, 0);
      tick();
    end
    out_ready = 1'b0;
    chk("empty_valid", out_valid, 0);
    chk("empty_imm", immediate, 0);
    chk("empty_ext", immediate_ext, 0);
    chk("empty_zext", immediate_ext_z, 0);
    chk("empty_count", count, 0);

    // streaming at count = 2 across pointer wrap
    in_valid = 1'b1;
    instruction_in = 32'd100;
    tick();
    instruction_in = 32'd101;
    tick();
    chk("stream_pre_count", count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      instruction_in = 32'(102 + k);
      chk("stream_head", immediate, 64'(100 + k));
      tick();
      chk("stream_count", count, 2);
    end
    in_valid = 1'b0;
    chk("stream_tail0", immediate, 110);
    tick();
    chk("stream_tail1", immediate, 111);
    tick();
    out_ready = 1'b0;
    chk("stream_empty", count, 0);

    // backpressure holds head stable
    instruction_in = 32'h2345_0007;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    instruction_in = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_word", {opcode, reg_dest, reg_source_1, reg_source_2,
                      immediate}, 32'h2345_0007);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_count", count, 0);

    // flush beats push and pop
    in_valid = 1'b1;
    instruction_in = 32'h11;
    tick();
    instruction_in = 32'h22;
    tick();
    instruction_in = 32'h33;
    tick();
    chk("fl_pre_count", count, 3);
    flush = 1'b1;
    instruction_in = 32'h44;
    out_ready = 1'b1;
    #1 chk("fl_in_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    instruction_in = 32'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fl_next_count", count, 1);
    chk("fl_next_imm", immediate, 16'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // async reset with clock stopped
    in_valid = 1'b1;
    instruction_in = 32'h66;
    tick();
    instruction_in = 32'h77;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_count", count, 2);
    clk_en = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    #5 reset = 1'b1;
    clk_en = 1'b1;
    tick();
    chk("ar_after_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
